lcd_scheduler: RTL and testbench

Sequencer and two-port arbiter for the 16x2 character LCD bus. It runs the LCD power-on init sequence, then grants the display to one of two requesters, for example the game-message writer and the score writer. Each granted byte or command goes out with correct setup, enable-pulse and execution-wait timing. Its output is the packed 11-bit LCD bus used throughout the design.

---
 rtl/lcd_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_lcd_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scheduler.sv
// lcd_scheduler: power-on init sequencer and two-port arbiter for the
// 16x2 character LCD bus. Each granted byte goes out with a setup phase,
// an enable pulse and a post-strobe execution wait.
//
// Ports:
//   Clk         system clock
//   reset       asynchronous, active-low
//   req[1:0]    per-port request, level, held until ack
//   rs[1:0]     per-port register select (0 command, 1 data)
//   din[15:0]   per-port byte, port p on din[8p+7:8p]
//   lock[1:0]   per-port grant lock for multi-byte strings
//   ack[1:0]    one-cycle completion pulse per port
//   init_done   high once the init sequence has completed
//   n_LCD_DATA  packed LCD bus {ON, RS, EN, DB[7:0]}
//
// Build option: LCD_SCHED_RR_EN selects round-robin arbitration between
// the ports; without it port 0 has fixed priority over port 1.
module lcd_scheduler #(
    parameter int unsigned POR_WAIT   = 750000,
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned EN_CYC     = 12,
    parameter int unsigned EXEC_WAIT  = 2500,
    parameter int unsigned CLEAR_WAIT = 100000
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  rs,
    input  logic [15:0] din,
    input  logic [1:0]  lock,
    output logic [1:0]  ack,
    output logic        init_done,
    output logic [10:0] n_LCD_DATA
);

    localparam int unsigned CNT_W = 20;

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_WAIT - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_WAIT - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT - 1);

    localparam logic [2:0] ST_POR    = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_SETUP  = 3'd3;
    localparam logic [2:0] ST_STROBE = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;

    typedef struct packed {
        logic       on;
        logic       rs;
        logic       en;
        logic [7:0] db;
    } lcd_bus_t;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic             init_done_q, init_done_d;
    logic [1:0]       ack_q, ack_d;
    lcd_bus_t         bus_q, bus_d;
    logic             owner_q, owner_d;
`ifdef LCD_SCHED_RR_EN
    logic             rr_ptr_q, rr_ptr_d;
`endif

    logic             lock_hit;
    logic             win;
    logic             is_clear;
    logic [CNT_W-1:0] wait_last;

    // Init command ROM: function set, display on, clear, entry mode.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    // Clear/home commands need the long execution wait.
    always_comb begin
        is_clear  = !bus_q.rs && (bus_q.db == 8'h01 || bus_q.db == 8'h02 || bus_q.db == 8'h03);
        wait_last = is_clear ? CLEAR_LAST : EXEC_LAST;
    end

    // Winner select; a lock only applies at the sample that ends its ack cycle.
    always_comb begin
        lock_hit = |(ack_q & lock & req);
        if (lock_hit) begin
            win = owner_q;
        end else if (&req) begin
`ifdef LCD_SCHED_RR_EN
            win = rr_ptr_q;
`else
            win = 1'b0;
`endif
        end else begin
            win = req[1];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        ack_d       = 2'b00;
        bus_d       = bus_q;
        owner_d     = owner_q;
`ifdef LCD_SCHED_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            ST_POR: begin
                bus_d.on = 1'b1;
                if (cnt_q == POR_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_INIT: begin
                bus_d   = {1'b1, 1'b0, 1'b0, init_byte(init_idx_q)};
                state_d = ST_SETUP;
                cnt_d   = '0;
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (init_done_q && (|req)) begin
                    owner_d = win;
                    bus_d   = {1'b1, rs[win], 1'b0, (win ? din[15:8] : din[7:0])};
                    state_d = ST_SETUP;
`ifdef LCD_SCHED_RR_EN
                    rr_ptr_d = ~win;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d  = ST_STROBE;
                    cnt_d    = '0;
                    bus_d.en = 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == EN_LAST) begin
                    state_d  = ST_WAIT;
                    cnt_d    = '0;
                    bus_d.en = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (!init_done_q) begin
                        if (init_idx_q == 2'd3) begin
                            state_d     = ST_IDLE;
                            init_done_d = 1'b1;
                            init_idx_d  = 2'd0;
                        end else begin
                            state_d    = ST_INIT;
                            init_idx_d = init_idx_q + 2'd1;
                        end
                    end else begin
                        state_d        = ST_IDLE;
                        ack_d[owner_q] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_POR;
            cnt_q       <= '0;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            ack_q       <= 2'b00;
            bus_q       <= '0;
            owner_q     <= 1'b0;
`ifdef LCD_SCHED_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            ack_q       <= ack_d;
            bus_q       <= bus_d;
            owner_q     <= owner_d;
`ifdef LCD_SCHED_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign init_done  = init_done_q;
    assign n_LCD_DATA = bus_q;

endmodule

// File: tb/tb_lcd_scheduler.sv
// tb_lcd_scheduler: scoreboard bench for lcd_scheduler with short timing
// parameters. Expected bytes are queued per port when driven and checked
// when the matching ack appears; init bytes and arbitration order are
// queued by the test sequence.
module tb_lcd_scheduler;

    localparam int unsigned POR_WAIT   = 20;
    localparam int unsigned SETUP_CYC  = 2;
    localparam int unsigned EN_CYC     = 4;
    localparam int unsigned EXEC_WAIT  = 10;
    localparam int unsigned CLEAR_WAIT = 30;

    logic        Clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  rs;
    logic [15:0] din;
    logic [1:0]  lock;
    logic [1:0]  ack;
    logic        init_done;
    logic [10:0] n_LCD_DATA;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        logic       lk;
    } tx_t;

    tx_t        tx_q[2][$];
    tx_t        exp_q[2][$];
    int         exp_order[$];
    logic [7:0] exp_init[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int acks_seen;

    lcd_scheduler #(
        .POR_WAIT  (POR_WAIT),
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .EXEC_WAIT (EXEC_WAIT),
        .CLEAR_WAIT(CLEAR_WAIT)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .req       (req),
        .rs        (rs),
        .din       (din),
        .lock      (lock),
        .ack       (ack),
        .init_done (init_done),
        .n_LCD_DATA(n_LCD_DATA)
    );

    always #5 Clk = ~Clk;

    // Cycle index: 1 at the first rising edge after reset release.
    always @(posedge Clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input logic r, input logic [7:0] d);
        return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? int'(CLEAR_WAIT) : int'(EXEC_WAIT);
    endfunction

    // Bus monitor and scoreboard.
    logic       en_prev, done_prev, first_seen, en_now;
    int         en_len, last_rise, last_fall, init_cnt, prev_w, mp;
    logic [7:0] b_db, e_db;
    logic       b_rs;
    tx_t        m_it;

    always @(negedge Clk) begin
        if (!reset) begin
            en_prev    = 1'b0;
            done_prev  = 1'b0;
            first_seen = 1'b0;
            en_len     = 0;
            last_rise  = 0;
            last_fall  = 0;
            init_cnt   = 0;
            prev_w     = 0;
            acks_seen  = 0;
        end else begin
            en_now = n_LCD_DATA[8];
            if (en_now && !en_prev) begin
                if (!first_seen) begin
                    chk("por_to_first_en", cyc, POR_WAIT + SETUP_CYC + 1);
                    first_seen = 1'b1;
                end
                b_db   = n_LCD_DATA[7:0];
                b_rs   = n_LCD_DATA[9];
                en_len = 1;
                if (!init_done) begin
                    if (exp_init.size() == 0) begin
                        chk("init_extra_burst", 32'(b_db), 32'hFFFF);
                    end else begin
                        e_db = exp_init.pop_front();
                        chk("init_db", 32'(b_db), 32'(e_db));
                        chk("init_rs", 32'(b_rs), 0);
                        if (init_cnt > 0)
                            chk("init_spacing", cyc - last_rise, SETUP_CYC + EN_CYC + prev_w + 1);
                        prev_w = wait_of(1'b0, e_db);
                        init_cnt++;
                    end
                end
                last_rise = cyc;
            end else if (en_now) begin
                en_len++;
            end
            if (!en_now && en_prev) begin
                chk("en_width", en_len, EN_CYC);
                last_fall = cyc;
            end
            if (init_done && !done_prev) begin
                chk("init_done_delay", cyc - last_fall, EXEC_WAIT);
                chk("init_burst_count", init_cnt, 4);
            end
            if (ack != 2'b00) begin
                acks_seen++;
                if (!init_done) begin
                    chk("ack_during_init", 32'(ack), 0);
                end else if (exp_order.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 0);
                end else begin
                    mp = exp_order.pop_front();
                    chk("ack_port", 32'(ack), 32'(2'b01 << mp));
                    if (ack[mp] && exp_q[mp].size() > 0) begin
                        m_it = exp_q[mp].pop_front();
                        chk("bus_db", 32'(b_db), 32'(m_it.db));
                        chk("bus_rs", 32'(b_rs), 32'(m_it.rs));
                        chk("exec_wait", cyc - last_fall, wait_of(m_it.rs, m_it.db));
                    end
                end
            end
            en_prev   = en_now;
            done_prev = init_done;
        end
    end

    // Drain a port's transmit queue; the next byte goes out in the ack cycle.
    task automatic port_drv(input int p);
        tx_t it;
        int  g;
        @(negedge Clk);
        while (tx_q[p].size() > 0) begin
            it = tx_q[p].pop_front();
            exp_q[p].push_back(it);
            rs[p]            = it.rs;
            din[p*8 +: 8]    = it.db;
            lock[p]          = it.lk;
            req[p]           = 1'b1;
            g = 0;
            do begin
                @(negedge Clk);
                g++;
            end while (!ack[p] && g < 400);
            if (!ack[p]) begin
                chk("drv_ack_timeout", 32'(ack[p]), 1);
                break;
            end
        end
        req[p]  = 1'b0;
        lock[p] = 1'b0;
    endtask

    // One transaction with latency check; inputs are scrambled and req
    // dropped right after the sample edge, which must not affect the result.
    task automatic single_tx(input int p, input logic r, input logic [7:0] d, input int exp_lat);
        tx_t it;
        int  n;
        it.rs = r;
        it.db = d;
        it.lk = 1'b0;
        exp_q[p].push_back(it);
        exp_order.push_back(p);
        @(negedge Clk);
        rs[p]         = r;
        din[p*8 +: 8] = d;
        lock[p]       = 1'b0;
        req[p]        = 1'b1;
        n = 0;
        do begin
            @(posedge Clk);
            n++;
            if (n == 1) begin
                #1;
                req[p]        = 1'b0;
                rs[p]         = ~r;
                din[p*8 +: 8] = ~d;
            end
            @(negedge Clk);
        end while (!ack[p] && n < 400);
        chk("ack_latency", n, exp_lat);
    endtask

    task automatic release_and_init(input logic hold_req);
        int g;
        exp_init.push_back(8'h38);
        exp_init.push_back(8'h0C);
        exp_init.push_back(8'h01);
        exp_init.push_back(8'h06);
        @(negedge Clk);
        if (hold_req) begin
            rs[0]     = 1'b1;
            din[7:0]  = 8'h55;
            req[0]    = 1'b1;
        end
        reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("on_after_first_edge", 32'(n_LCD_DATA[10]), 1);
        chk("en_low_in_por", 32'(n_LCD_DATA[8]), 0);
        g = 0;
        do begin
            @(negedge Clk);
            g++;
        end while (!init_done && g < 3000);
        req[0] = 1'b0;
        chk("init_done_seen", 32'(init_done), 1);
        chk("init_no_ack", acks_seen, 0);
        chk("init_queue_empty", exp_init.size(), 0);
    endtask

    function automatic tx_t mk(input logic r, input logic [7:0] d, input logic lk);
        tx_t t;
        t.rs = r;
        t.db = d;
        t.lk = lk;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset = 1'b0;
        req   = 2'b00;
        rs    = 2'b00;
        din   = 16'h0000;
        lock  = 2'b00;
        #1;
        chk("rst_bus", 32'(n_LCD_DATA), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_init_done", 32'(init_done), 0);
        repeat (3) @(negedge Clk);

        // Init with a request held throughout; it must not be served.
        release_and_init(1'b1);

        // Single data write on port 1.
        single_tx(1, 1'b1, 8'h41, 1 + SETUP_CYC + EN_CYC + EXEC_WAIT);

        // Both ports request together, two bytes each.
        tx_q[0].push_back(mk(1'b1, 8'h30, 1'b0));
        tx_q[0].push_back(mk(1'b1, 8'h31, 1'b0));
        tx_q[1].push_back(mk(1'b1, 8'h50, 1'b0));
        tx_q[1].push_back(mk(1'b1, 8'h51, 1'b0));
`ifdef LCD_SCHED_RR_EN
        exp_order.push_back(0);
        exp_order.push_back(1);
        exp_order.push_back(0);
        exp_order.push_back(1);
`else
        exp_order.push_back(0);
        exp_order.push_back(0);
        exp_order.push_back(1);
        exp_order.push_back(1);
`endif
        fork
            port_drv(0);
            port_drv(1);
        join

        // Locked string "ABC" on port 1 while port 0 waits.
        tx_q[1].push_back(mk(1'b1, 8'h41, 1'b1));
        tx_q[1].push_back(mk(1'b1, 8'h42, 1'b1));
        tx_q[1].push_back(mk(1'b1, 8'h43, 1'b1));
        tx_q[0].push_back(mk(1'b1, 8'h60, 1'b0));
        exp_order.push_back(1);
        exp_order.push_back(1);
        exp_order.push_back(1);
        exp_order.push_back(0);
        fork
            port_drv(1);
            begin
                repeat (3) @(negedge Clk);
                port_drv(0);
            end
        join

        // Wait-length boundaries: home uses the long wait, 0x04 and data 0x01 do not.
        single_tx(0, 1'b0, 8'h02, 1 + SETUP_CYC + EN_CYC + CLEAR_WAIT);
        single_tx(0, 1'b0, 8'h04, 1 + SETUP_CYC + EN_CYC + EXEC_WAIT);
        single_tx(1, 1'b1, 8'h01, 1 + SETUP_CYC + EN_CYC + EXEC_WAIT);
        single_tx(1, 1'b0, 8'h03, 1 + SETUP_CYC + EN_CYC + CLEAR_WAIT);

        // Reset in the middle of a strobe.
        @(negedge Clk);
        rs[0]    = 1'b1;
        din[7:0] = 8'h5A;
        req[0]   = 1'b1;
        g = 0;
        do begin
            @(negedge Clk);
            g++;
        end while (!n_LCD_DATA[8] && g < 100);
        chk("strobe_reached", 32'(n_LCD_DATA[8]), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_bus", 32'(n_LCD_DATA), 0);
        chk("midrst_ack", 32'(ack), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        req  = 2'b00;
        lock = 2'b00;
        exp_order.delete();
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (3) @(negedge Clk);
        release_and_init(1'b0);
        single_tx(1, 1'b1, 8'h43, 1 + SETUP_CYC + EN_CYC + EXEC_WAIT);

        repeat (5) @(negedge Clk);
        chk("order_queue_empty", exp_order.size(), 0);
        chk("port0_queue_empty", exp_q[0].size(), 0);
        chk("port1_queue_empty", exp_q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
